// File: rtl/gps_pkg.sv
// gps_pkg: shared constants, FSM state type and PRN tap table for the C/A generator
package gps_pkg;
  localparam int CA_LEN = 1023;
  localparam int BLK_W = 13;
  localparam int SV_MAX = 32;
  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;
  function automatic logic [7:0] ca_taps(input logic [5:0] sv);
    case (sv)
      6'd1: return 8'h26;
      6'd2: return 8'h37;
      6'd3: return 8'h48;
      6'd4: return 8'h59;
      6'd5: return 8'h19;
      6'd6: return 8'h2A;
      6'd7: return 8'h18;
      6'd8: return 8'h29;
      6'd9: return 8'h3A;
      6'd10: return 8'h23;
      6'd11: return 8'h34;
      6'd12: return 8'h56;
      6'd13: return 8'h67;
      6'd14: return 8'h78;
      6'd15: return 8'h89;
      6'd16: return 8'h9A;
      6'd17: return 8'h14;
      6'd18: return 8'h25;
      6'd19: return 8'h36;
      6'd20: return 8'h47;
      6'd21: return 8'h58;
      6'd22: return 8'h69;
      6'd23: return 8'h13;
      6'd24: return 8'h46;
      6'd25: return 8'h57;
      6'd26: return 8'h68;
      6'd27: return 8'h79;
      6'd28: return 8'h8A;
      6'd29: return 8'h16;
      6'd30: return 8'h27;
      6'd31: return 8'h38;
      6'd32: return 8'h49;
      default: return 8'h26;
    endcase
  endfunction
endpackage

// File: rtl/gps_ca_gen_if.sv
// gps_ca_gen_if: request/result bundle between the code core and the C/A generator
interface gps_ca_gen_if;
  import gps_pkg::*;
  logic [5:0] sv_num;
  logic gen_next;
  logic [BLK_W-1:0] ca_code;
  logic [9:0] chip_idx;
  logic code_valid;
  logic sv_err;
  modport master (output sv_num, gen_next, input ca_code, chip_idx, code_valid, sv_err);
  modport slave (input sv_num, gen_next, output ca_code, chip_idx, code_valid, sv_err);
endinterface

// File: rtl/gps_ca_lfsr.sv
// gps_ca_lfsr: G1/G2 Gold-code register pair producing one C/A chip per shift
module gps_ca_lfsr (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  output logic       chip
);
  logic [10:1] g1_q, g1_d, g2_q, g2_d;
  // Reload has priority over shifting; chip is taken from the pre-shift state
  always_comb begin
    g1_d = load ? '1 : en ? {g1_q[9:1], g1_q[3] ^ g1_q[10]} : g1_q;
    g2_d = load ? '1 : en ? {g2_q[9:1], ^{g2_q[2], g2_q[3], g2_q[6], g2_q[8], g2_q[9], g2_q[10]}} : g2_q;
    chip = g1_q[10] ^ g2_q[s1] ^ g2_q[s2];
  end
  // Register update, all-ones after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      g1_q <= '1;
      g2_q <= '1;
    end else begin
      g1_q <= g1_d;
      g2_q <= g2_d;
    end
  end
endmodule

// File: rtl/gps_ca_gen.sv
// gps_ca_gen: produces 13-chip blocks of the GPS C/A code for a selected PRN on request
module gps_ca_gen
  import gps_pkg::*;
(
  input logic wb_clk_i,
  input logic wb_rst_i,
  gps_ca_gen_if.slave bus
);
  state_t state_q, state_d;
  logic gen_next_q;
  logic [5:0] sv_q, sv_d;
  logic [9:0] phase_q, phase_d, chip_idx_q, chip_idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] sreg_q, sreg_d, ca_code_q, ca_code_d;
  logic code_valid_q, code_valid_d, sv_err_q, sv_err_d;
  logic start, legal, lfsr_load, lfsr_en, chip;
  logic [7:0] taps;
  assign taps = ca_taps(sv_q);
  gps_ca_lfsr u_lfsr (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .load(lfsr_load),
    .en  (lfsr_en),
    .s1  (taps[7:4]),
    .s2  (taps[3:0]),
    .chip(chip)
  );
  // Request acceptance, chip generation and block completion
  always_comb begin
    state_d = state_q;
    sv_d = sv_q;
    phase_d = phase_q;
    chip_idx_d = chip_idx_q;
    cnt_d = cnt_q;
    sreg_d = sreg_q;
    ca_code_d = ca_code_q;
    code_valid_d = code_valid_q;
    sv_err_d = sv_err_q;
    lfsr_load = 1'b0;
    lfsr_en = 1'b0;
    start = bus.gen_next & ~gen_next_q;
    legal = bus.sv_num != 6'd0 && bus.sv_num <= 6'(SV_MAX);
    case (state_q)
      GEN: begin
        lfsr_en = 1'b1;
        lfsr_load = phase_q == 10'(CA_LEN - 1);
        phase_d = lfsr_load ? 10'd0 : phase_q + 10'd1;
        sreg_d = {sreg_q[BLK_W-2:0], chip};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(BLK_W - 1)) begin
          ca_code_d = sreg_d;
          code_valid_d = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        if (start) begin
          code_valid_d = 1'b0;
          sv_err_d = ~legal;
          state_d = legal ? GEN : IDLE;
          if (legal) begin
            sv_d = bus.sv_num;
            cnt_d = 4'd0;
            lfsr_load = bus.sv_num != sv_q;
            phase_d = lfsr_load ? 10'd0 : phase_q;
            chip_idx_d = phase_d;
          end
        end
      end
    endcase
  end
  // State and output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      gen_next_q <= 1'b0;
      sv_q <= '0;
      phase_q <= '0;
      chip_idx_q <= '0;
      cnt_q <= '0;
      sreg_q <= '0;
      ca_code_q <= '0;
      code_valid_q <= 1'b0;
      sv_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gen_next_q <= bus.gen_next;
      sv_q <= sv_d;
      phase_q <= phase_d;
      chip_idx_q <= chip_idx_d;
      cnt_q <= cnt_d;
      sreg_q <= sreg_d;
      ca_code_q <= ca_code_d;
      code_valid_q <= code_valid_d;
      sv_err_q <= sv_err_d;
    end
  end
  assign bus.ca_code = ca_code_q;
  assign bus.chip_idx = chip_idx_q;
  assign bus.code_valid = code_valid_q;
  assign bus.sv_err = sv_err_q;
endmodule

// File: tb/tb_gps_ca_gen.sv
// tb_gps_ca_gen: vector table, corner sequences and randomized requests against a code-table model
module tb_gps_ca_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  gps_ca_gen_if bus ();
  gps_ca_gen dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int s1t [1:32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int s2t [1:32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};
  bit ca_tab [1:32][0:1022];
  int msv, mph;
  typedef struct {
    logic [5:0] sv;
    int lat;
    logic valid;
    logic err;
    logic [9:0] idx;
    logic chk_top;
    logic [9:0] top;
  } vec_t;
  vec_t vecs [6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic build_table();
    for (int p = 1; p <= 32; p++) begin
      int g1 [1:10];
      int g2 [1:10];
      for (int k = 1; k <= 10; k++) begin
        g1[k] = 1;
        g2[k] = 1;
      end
      for (int i = 0; i < 1023; i++) begin
        int f1, f2;
        ca_tab[p][i] = bit'(g1[10] ^ g2[s1t[p]] ^ g2[s2t[p]]);
        f1 = g1[3] ^ g1[10];
        f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
        for (int k = 10; k >= 2; k--) begin
          g1[k] = g1[k-1];
          g2[k] = g2[k-1];
        end
        g1[1] = f1;
        g2[1] = f2;
      end
    end
  endtask
  task automatic model_req(input int sv, output logic [12:0] blk, output logic [9:0] idx);
    if (sv != msv) mph = 0;
    msv = sv;
    idx = 10'(mph);
    for (int k = 0; k < 13; k++) blk[12-k] = ca_tab[sv][(mph + k) % 1023];
    mph = (mph + 13) % 1023;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.gen_next = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    msv = 0;
    mph = 0;
  endtask
  task automatic request(input logic [5:0] sv, output int lat);
    @(negedge clk);
    bus.sv_num = sv;
    bus.gen_next = 1'b1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.code_valid || bus.sv_err) begin
        lat = n;
        break;
      end
    end
    @(negedge clk);
    bus.gen_next = 1'b0;
  endtask
  task automatic checked_req(input string tag, input int sv);
    int lat;
    logic [12:0] eb;
    logic [9:0] ei;
    request(6'(sv), lat);
    model_req(sv, eb, ei);
    chk({tag, " latency"}, lat, 14);
    chk({tag, " ca_code"}, bus.ca_code, eb);
    chk({tag, " chip_idx"}, bus.chip_idx, ei);
  endtask
  initial begin
    int lat;
    int sv;
    logic [12:0] eb;
    logic [9:0] ei;
    bus.sv_num = 6'd0;
    bus.gen_next = 1'b0;
    build_table();
    vecs[0] = '{6'd1, 14, 1'b1, 1'b0, 10'd0, 1'b1, 10'o1440};
    vecs[1] = '{6'd2, 14, 1'b1, 1'b0, 10'd0, 1'b1, 10'o1620};
    vecs[2] = '{6'd2, 14, 1'b1, 1'b0, 10'd13, 1'b0, 10'd0};
    vecs[3] = '{6'd1, 14, 1'b1, 1'b0, 10'd0, 1'b1, 10'o1440};
    vecs[4] = '{6'd0, 1, 1'b0, 1'b1, 10'd0, 1'b0, 10'd0};
    vecs[5] = '{6'd33, 1, 1'b0, 1'b1, 10'd0, 1'b0, 10'd0};
    do_reset();
    #1;
    chk("reset ca_code", bus.ca_code, 0);
    chk("reset chip_idx", bus.chip_idx, 0);
    chk("reset code_valid", bus.code_valid, 0);
    chk("reset sv_err", bus.sv_err, 0);
    for (int i = 0; i < 6; i++) begin
      request(vecs[i].sv, lat);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d code_valid", i), bus.code_valid, vecs[i].valid);
      chk($sformatf("vec%0d sv_err", i), bus.sv_err, vecs[i].err);
      if (vecs[i].valid) chk($sformatf("vec%0d chip_idx", i), bus.chip_idx, vecs[i].idx);
      if (vecs[i].chk_top) chk($sformatf("vec%0d ca_code top", i), bus.ca_code[12:3], vecs[i].top);
    end
    repeat (5) @(negedge clk);
    chk("illegal code_valid held low", bus.code_valid, 0);
    do_reset();
    for (int b = 1; b <= 80; b++) begin
      checked_req($sformatf("wrap blk%0d", b), 1);
      if (b == 79) chk("blk79 chip_idx", bus.chip_idx, 1014);
      if (b == 80) chk("blk80 chip_idx", bus.chip_idx, 4);
    end
    do_reset();
    @(negedge clk);
    bus.sv_num = 6'd1;
    bus.gen_next = 1'b1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.code_valid) begin
        lat = n;
        break;
      end
      if (n == 2 || n == 6) bus.gen_next = 1'b0;
      if (n == 4) bus.gen_next = 1'b1;
    end
    bus.gen_next = 1'b0;
    model_req(1, eb, ei);
    chk("retrigger latency", lat, 14);
    chk("retrigger ca_code", bus.ca_code, eb);
    repeat (20) @(negedge clk);
    chk("retrigger hold valid", bus.code_valid, 1);
    chk("retrigger hold idx", bus.chip_idx, 0);
    checked_req("after retrigger", 1);
    checked_req("switch prn2", 2);
    chk("switch prn2 idx", bus.chip_idx, 0);
    @(negedge clk);
    bus.sv_num = 6'd1;
    bus.gen_next = 1'b1;
    repeat (6) @(negedge clk);
    chk("midgen valid low", bus.code_valid, 0);
    rst = 1'b1;
    bus.gen_next = 1'b0;
    @(posedge clk);
    #1;
    chk("midgen rst ca_code", bus.ca_code, 0);
    chk("midgen rst chip_idx", bus.chip_idx, 0);
    chk("midgen rst code_valid", bus.code_valid, 0);
    chk("midgen rst sv_err", bus.sv_err, 0);
    @(negedge clk);
    rst = 1'b0;
    msv = 0;
    mph = 0;
    repeat (16) @(negedge clk);
    chk("post rst no stray valid", bus.code_valid, 0);
    checked_req("post rst", 1);
    chk("post rst top", bus.ca_code[12:3], 10'o1440);
    do_reset();
    sv = $urandom_range(1, 32);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) sv = $urandom_range(1, 32);
      checked_req($sformatf("rand%0d sv%0d", i, sv), sv);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
